// File: rtl/int_to_fp32_norm.sv
// int_to_fp32_norm: pipelined 64-bit integer to IEEE-754 binary32 converter with round-to-nearest-even
module lzc64 (
  input  logic [63:0] a,
  output logic [6:0]  cnt
);
  // leading-zero count of a; 64 when a is zero
  always_comb begin
    cnt = 7'd64;
    for (int i = 0; i < 64; i++)
      if (a[i]) cnt = 7'(63 - i);
  end
endmodule

module int_to_fp32_norm #(
  parameter bit SIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_inexact
);
  logic        v1, v2, v3;
  logic        r1, r2;
  logic        s1_sign, s2_sign, s2_zero;
  logic [63:0] s1_mag, s2_norm;
  logic [5:0]  s2_lz;
  logic [6:0]  lz;
  logic        in_sign;
  logic [63:0] in_mag, norm;
  logic [22:0] frac;
  logic        guard, sticky, rnd;
  logic [23:0] frac_r;
  logic [7:0]  exp_r;

  assign r2        = ~v3 | out_ready;
  assign r1        = ~v2 | r2;
  assign in_ready  = ~v1 | r1;
  assign out_valid = v3;

  lzc64 u_lzc (
    .a   (s1_mag),
    .cnt (lz)
  );

  // per-stage datapath: absolute value, normalize shift, round and exponent adjust
  always_comb begin
    in_sign = SIGNED & in_data[63];
    in_mag  = in_sign ? ~in_data + 64'd1 : in_data;
    norm    = s1_mag << lz[5:0];
    frac    = s2_norm[62:40];
    guard   = s2_norm[39];
    sticky  = |s2_norm[38:0];
    rnd     = guard & (sticky | frac[0]);
    frac_r  = {1'b0, frac} + 24'(rnd);
    exp_r   = 8'd190 - {2'b00, s2_lz} + 8'(frac_r[23]);
  end

  // elastic pipeline: a stage loads only on a real transfer so bubbles never disturb held data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1          <= 1'b0;
      v2          <= 1'b0;
      v3          <= 1'b0;
      s1_sign     <= 1'b0;
      s1_mag      <= 64'd0;
      s2_sign     <= 1'b0;
      s2_zero     <= 1'b0;
      s2_norm     <= 64'd0;
      s2_lz       <= 6'd0;
      out_data    <= 32'd0;
      out_inexact <= 1'b0;
    end else begin
      if (in_ready) v1 <= in_valid;
      if (in_ready & in_valid) begin
        s1_sign <= in_sign;
        s1_mag  <= in_mag;
      end
      if (r1) v2 <= v1;
      if (r1 & v1) begin
        s2_sign <= s1_sign;
        s2_norm <= norm;
        s2_lz   <= lz[5:0];
        s2_zero <= lz[6];
      end
      if (r2) v3 <= v2;
      if (r2 & v2) begin
        out_data    <= s2_zero ? 32'd0 : {s2_sign, exp_r, frac_r[22:0]};
        out_inexact <= ~s2_zero & (guard | sticky);
      end
    end
  end
endmodule

// File: tb/tb_int_to_fp32_norm.sv
// tb_int_to_fp32_norm: scoreboard bench for signed and unsigned converter instances
module tb_int_to_fp32_norm;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [63:0] in_data = 64'd0;
  logic        in_ready_s, out_valid_s, out_inexact_s;
  logic        in_ready_u, out_valid_u, out_inexact_u;
  logic [31:0] out_data_s, out_data_u;
  int          checks = 0;
  int          failures = 0;
  logic [32:0] q_s[$];
  logic [32:0] q_u[$];
  logic [32:0] exp_e;
  logic [32:0] hold_s;
  logic        hold_v = 1'b0;
  bit          rnd_done = 1'b0;

  always #5 clk = ~clk;

  int_to_fp32_norm #(.SIGNED(1'b1)) dut_s (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready_s),
    .in_data     (in_data),
    .out_valid   (out_valid_s),
    .out_ready   (out_ready),
    .out_data    (out_data_s),
    .out_inexact (out_inexact_s)
  );

  int_to_fp32_norm #(.SIGNED(1'b0)) dut_u (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready_u),
    .in_data     (in_data),
    .out_valid   (out_valid_u),
    .out_ready   (out_ready),
    .out_data    (out_data_u),
    .out_inexact (out_inexact_u)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // reference: locate the MSB, keep 24 significant bits, round the discarded remainder to nearest even
  function automatic logic [32:0] ref_conv(input logic [63:0] x, input bit sgn);
    logic        s;
    logic [63:0] m, q, rem, half;
    int          e, sh;
    s = sgn && x[63];
    m = s ? -x : x;
    if (m == 64'd0) return 33'd0;
    e = 63;
    while (!m[e]) e--;
    rem = 64'd0;
    if (e <= 23) q = m << (23 - e);
    else begin
      sh   = e - 23;
      q    = m >> sh;
      rem  = m & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 64'd1;
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        e++;
      end
    end
    return {rem != 64'd0, s, 8'(e + 127), q[22:0]};
  endfunction

  function automatic logic [63:0] gen();
    logic [63:0] r;
    int          s;
    r = {$urandom, $urandom};
    s = int'($urandom_range(1, 39));
    case ($urandom_range(0, 4))
      0: return r;
      1: return r >> $urandom_range(0, 63);
      2: return 64'($urandom_range(0, 300));
      3: return -(r >> $urandom_range(30, 62));
      default: return (((r & 64'hFF_FFFF) | 64'h80_0000) << s) | (64'd1 << (s - 1));
    endcase
  endfunction

  // monitor: stability while stalled, scoreboard pop on output transfer, push on input transfer
  always @(negedge clk) begin
    if (!rst_n) begin
      q_s.delete();
      q_u.delete();
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("hold_valid", 64'(out_valid_s), 64'd1);
        chk("hold_data", 64'({out_inexact_s, out_data_s}), 64'(hold_s));
      end
      hold_v = out_valid_s & ~out_ready;
      hold_s = {out_inexact_s, out_data_s};
      if (out_valid_s && out_ready) begin
        if (q_s.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_out_signed: got %h expected none", {out_inexact_s, out_data_s});
        end else begin
          exp_e = q_s.pop_front();
          chk("out_signed", 64'({out_inexact_s, out_data_s}), 64'(exp_e));
        end
      end
      if (out_valid_u && out_ready) begin
        if (q_u.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_out_unsigned: got %h expected none", {out_inexact_u, out_data_u});
        end else begin
          exp_e = q_u.pop_front();
          chk("out_unsigned", 64'({out_inexact_u, out_data_u}), 64'(exp_e));
        end
      end
      if (in_valid && in_ready_s) q_s.push_back(ref_conv(in_data, 1'b1));
      if (in_valid && in_ready_u) q_u.push_back(ref_conv(in_data, 1'b0));
    end
  end

  task automatic send(input logic [63:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!(in_ready_s && in_ready_u) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++; failures++;
      $display("FAIL send_timeout: got no in_ready expected in_ready within 200 cycles");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom};
  endtask

  task automatic drain();
    int n = 0;
    while ((q_s.size() != 0 || q_u.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", 64'(q_s.size() + q_u.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n, k;
    logic        acc;
    logic [63:0] dir [10];
    dir = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF,
            64'h0100_0001, 64'h0100_0003, 64'h00FF_FFFF, 64'h0100_0000, 64'h0000_0000_0200_0002, 64'hFFFF_FFFF_FF00_0001};
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid_s), 64'd0);
    chk("rst_out_data", 64'(out_data_s), 64'd0);
    chk("rst_out_inexact", 64'(out_inexact_s), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready_s), 64'd1);
    @(posedge clk); #1;

    send(64'd1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid_s && n < 10);
    chk("latency", 64'(n), 64'd3);
    @(posedge clk); #1;
    drain();

    foreach (dir[i]) begin
      in_valid = 1'b1;
      in_data  = dir[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();

    out_ready = 1'b0;
    k = 0;
    in_valid = 1'b1;
    in_data  = 64'd1;
    repeat (6) begin
      @(negedge clk);
      acc = in_ready_s;
      @(posedge clk); #1;
      if (acc) begin
        k++;
        in_data = 64'(k + 1);
      end
    end
    @(negedge clk);
    chk("bp_accepts", 64'(k), 64'd3);
    chk("bp_in_ready_low", 64'(in_ready_s), 64'd0);
    chk("bp_head_data", 64'(out_data_s), 64'h3F80_0000);
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 0) chk("bp_ready_comb", 64'(in_ready_s), 64'd1);
      chk("bp_no_gap", 64'(out_valid_s), 64'd1);
      acc = in_ready_s & in_valid;
      @(posedge clk); #1;
      if (acc) begin
        k++;
        if (k == 5) in_valid = 1'b0;
        else in_data = 64'(k + 1);
      end
    end
    chk("bp_total_accepts", 64'(k), 64'd5);
    drain();

    in_valid = 1'b1;
    in_data  = 64'd5;
    @(posedge clk); #1;
    in_data  = 64'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk); #1;
    rst_n    = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid_s), 64'd0);
    chk("midrst_out_data", 64'(out_data_s), 64'd0);
    chk("midrst_out_inexact", 64'(out_inexact_s), 64'd0);
    chk("midrst_in_ready", 64'(in_ready_s), 64'd1);
    repeat (5) begin
      @(negedge clk);
      chk("midrst_no_stale", 64'({out_valid_s, out_valid_u}), 64'd0);
    end
    @(posedge clk); #1;

    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
          send(gen());
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
